// File: rtl/if_fetch_unit.sv
// Instruction-fetch / next-PC stage.
// Holds the PC and fetches each instruction over a req/ack handshake with a
// variable-latency instruction memory. Each fetched word is presented to the
// decoder for one EXEC cycle. At the end of that cycle the next PC is
// committed from the decoder's NPCOp select.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_3000,
   parameter logic [31:0] EXCEPT_PC = 32'h0000_4180
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic [2:0]  NPCOp,
   output logic [31:0] instr,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        nop,
   output logic [31:0] epc
);

   // Next-PC select codes shared with the decoder
   localparam logic [2:0] NPC_PLUS4  = 3'b000;
   localparam logic [2:0] NPC_BRANCH = 3'b001;
   localparam logic [2:0] NPC_JUMP   = 3'b010;
   localparam logic [2:0] NPC_EXCEPT = 3'b011;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_EXEC  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] epc_q, epc_d;

   // Next-PC arithmetic, all mod 2^32; unknown codes fall back to pc + 4
   function automatic logic [31:0] calc_npc(input logic [2:0]  op,
                                            input logic [31:0] pc_v,
                                            input logic [31:0] ins);
      logic [31:0]        p4;
      logic signed [31:0] br_off;
      logic [31:0]        npc;
      p4     = pc_v + 32'd4;
      br_off = {{14{ins[15]}}, ins[15:0], 2'b00};
      case (op)
         NPC_BRANCH: npc = p4 + $unsigned(br_off);
         NPC_JUMP:   npc = {p4[31:28], ins[25:0], 2'b00};
         NPC_EXCEPT: npc = EXCEPT_PC;
         default:    npc = p4;
      endcase
      return npc;
   endfunction

   // State and datapath registers; reset abandons any outstanding request at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         instr_q <= 32'h0;
         epc_q   <= 32'h0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         epc_q   <= epc_d;
      end
   end

   // Next-state logic: IDLE once after reset, then FETCH/EXEC alternation with ack wait
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  state_d = S_FETCH;
         S_FETCH: if (imem_ack) state_d = S_EXEC;
         S_EXEC:  state_d = S_FETCH;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath updates: instr only on a FETCH ack, pc/epc only at the end of EXEC
   always_comb begin
      pc_d    = pc_q;
      instr_d = instr_q;
      epc_d   = epc_q;
      if (state_q == S_FETCH && imem_ack) begin
         instr_d = imem_rdata;
      end
      if (state_q == S_EXEC) begin
         pc_d = calc_npc(NPCOp, pc_q, instr_q);
         if (NPCOp == NPC_EXCEPT) begin
            epc_d = pc_q;
         end
      end
   end

   // Outputs decoded from state: request only while fetching, valid only in EXEC
   always_comb begin
      imem_req = 1'b0;
      nop      = 1'b1;
      case (state_q)
         S_FETCH: imem_req = 1'b1;
         S_EXEC:  nop      = 1'b0;
         default: begin
            imem_req = 1'b0;
            nop      = 1'b1;
         end
      endcase
   end

   assign imem_addr = pc_q;
   assign pc        = pc_q;
   assign pc_plus4  = pc_q + 32'd4;
   assign instr     = instr_q;
   assign epc       = epc_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed testbench for if_fetch_unit: reset, handshake waits, every next-PC
// source, epc capture, PC wrap-around and reset during a pending fetch.
module tb_if_fetch_unit;

   localparam logic [2:0] NPC_PLUS4  = 3'b000;
   localparam logic [2:0] NPC_BRANCH = 3'b001;
   localparam logic [2:0] NPC_JUMP   = 3'b010;
   localparam logic [2:0] NPC_EXCEPT = 3'b011;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic [2:0]  NPCOp = NPC_PLUS4;

   logic        imem_req, nop;
   logic [31:0] imem_addr, instr, pc, pc_plus4, epc;

   logic        w_imem_req, w_nop;
   logic [31:0] w_imem_addr, w_instr, w_pc, w_pc_plus4, w_epc;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   if_fetch_unit dut (
      .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .NPCOp(NPCOp),
      .instr(instr), .pc(pc), .pc_plus4(pc_plus4), .nop(nop), .epc(epc)
   );

   // Second instance starting at the top of the address space, for wrap-around
   if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
      .clk(clk), .rst(rst), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .NPCOp(NPCOp),
      .instr(w_instr), .pc(w_pc), .pc_plus4(w_pc_plus4), .nop(w_nop), .epc(w_epc)
   );

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // From a FETCH cycle: ack with rd, then run EXEC with op; ends in the next FETCH
   task automatic fetch_exec(input logic [31:0] rd, input logic [2:0] op);
      imem_ack   = 1'b1;
      imem_rdata = rd;
      tick();
      imem_ack = 1'b0;
      NPCOp    = op;
      tick();
      NPCOp = NPC_PLUS4;
   endtask

   task automatic test_reset();
      @(negedge clk);
      @(negedge clk);
      checks++; if (pc !== 32'h3000) begin errors++; $display("FAIL rst_pc got=%h exp=%h", pc, 32'h3000); end
      checks++; if (instr !== 32'h0) begin errors++; $display("FAIL rst_instr got=%h exp=%h", instr, 32'h0); end
      checks++; if (nop !== 1'b1) begin errors++; $display("FAIL rst_nop got=%b exp=1", nop); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got=%b exp=0", imem_req); end
      checks++; if (epc !== 32'h0) begin errors++; $display("FAIL rst_epc got=%h exp=%h", epc, 32'h0); end
      checks++; if (pc_plus4 !== 32'h3004) begin errors++; $display("FAIL rst_pc_plus4 got=%h exp=%h", pc_plus4, 32'h3004); end
      checks++; if (w_pc_plus4 !== 32'h0) begin errors++; $display("FAIL rst_wrap_plus4 got=%h exp=%h", w_pc_plus4, 32'h0); end
   endtask

   task automatic test_fetch_basic();
      rst = 1'b0;
      tick();
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL t1_req got=%b exp=1", imem_req); end
      checks++; if (imem_addr !== 32'h3000) begin errors++; $display("FAIL t1_addr got=%h exp=%h", imem_addr, 32'h3000); end
      checks++; if (nop !== 1'b1) begin errors++; $display("FAIL t1_fetch_nop got=%b exp=1", nop); end
      imem_ack   = 1'b1;
      imem_rdata = 32'h3401_0005;
      tick();
      imem_ack = 1'b0;
      NPCOp    = NPC_PLUS4;
      checks++; if (nop !== 1'b0) begin errors++; $display("FAIL t1_exec_nop got=%b exp=0", nop); end
      checks++; if (instr !== 32'h3401_0005) begin errors++; $display("FAIL t1_instr got=%h exp=%h", instr, 32'h3401_0005); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL t1_exec_req got=%b exp=0", imem_req); end
      tick();
      checks++; if (nop !== 1'b1) begin errors++; $display("FAIL t1_nop_after got=%b exp=1", nop); end
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL t1_req2 got=%b exp=1", imem_req); end
      checks++; if (imem_addr !== 32'h3004) begin errors++; $display("FAIL t1_addr2 got=%h exp=%h", imem_addr, 32'h3004); end
   endtask

   task automatic test_wrap();
      checks++; if (w_imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr got=%h exp=%h", w_imem_addr, 32'h0); end
      checks++; if (w_pc_plus4 !== 32'h4) begin errors++; $display("FAIL wrap_plus4 got=%h exp=%h", w_pc_plus4, 32'h4); end
   endtask

   task automatic test_wait_states();
      imem_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL t2_req[%0d] got=%b exp=1", i, imem_req); end
         checks++; if (imem_addr !== 32'h3004) begin errors++; $display("FAIL t2_addr[%0d] got=%h exp=%h", i, imem_addr, 32'h3004); end
         checks++; if (nop !== 1'b1) begin errors++; $display("FAIL t2_nop[%0d] got=%b exp=1", i, nop); end
         checks++; if (instr !== 32'h3401_0005) begin errors++; $display("FAIL t2_instr[%0d] got=%h exp=%h", i, instr, 32'h3401_0005); end
         tick();
      end
      imem_ack   = 1'b1;
      imem_rdata = 32'h0000_0000;
      tick();
      imem_ack = 1'b0;
      checks++; if (nop !== 1'b0) begin errors++; $display("FAIL t2_exec_nop got=%b exp=0", nop); end
      checks++; if (instr !== 32'h0) begin errors++; $display("FAIL t2_instr_new got=%h exp=%h", instr, 32'h0); end
      tick();
      checks++; if (imem_addr !== 32'h3008) begin errors++; $display("FAIL t2_addr_next got=%h exp=%h", imem_addr, 32'h3008); end
   endtask

   task automatic test_branch();
      fetch_exec(32'h1000_FFFE, NPC_BRANCH);
      checks++; if (imem_addr !== 32'h3004) begin errors++; $display("FAIL t3_branch got=%h exp=%h", imem_addr, 32'h3004); end
      fetch_exec(32'h0, NPC_PLUS4);
      checks++; if (imem_addr !== 32'h3008) begin errors++; $display("FAIL t3_back got=%h exp=%h", imem_addr, 32'h3008); end
      fetch_exec(32'h1000_FFFE, NPC_PLUS4);
      checks++; if (imem_addr !== 32'h300C) begin errors++; $display("FAIL t3_plus4 got=%h exp=%h", imem_addr, 32'h300C); end
      fetch_exec(32'h0, NPC_PLUS4);
   endtask

   task automatic test_jump();
      checks++; if (imem_addr !== 32'h3010) begin errors++; $display("FAIL t4_start got=%h exp=%h", imem_addr, 32'h3010); end
      fetch_exec(32'h0800_0C10, NPC_JUMP);
      checks++; if (imem_addr !== 32'h3040) begin errors++; $display("FAIL t4_jump got=%h exp=%h", imem_addr, 32'h3040); end
      fetch_exec(32'h0800_0C05, NPC_JUMP);
      checks++; if (imem_addr !== 32'h3014) begin errors++; $display("FAIL t4_jump_back got=%h exp=%h", imem_addr, 32'h3014); end
   endtask

   task automatic test_except();
      fetch_exec(32'h0, NPC_EXCEPT);
      checks++; if (imem_addr !== 32'h4180) begin errors++; $display("FAIL t5_vec got=%h exp=%h", imem_addr, 32'h4180); end
      checks++; if (epc !== 32'h3014) begin errors++; $display("FAIL t5_epc got=%h exp=%h", epc, 32'h3014); end
      fetch_exec(32'h0, NPC_PLUS4);
      checks++; if (imem_addr !== 32'h4184) begin errors++; $display("FAIL t5_plus4 got=%h exp=%h", imem_addr, 32'h4184); end
      checks++; if (epc !== 32'h3014) begin errors++; $display("FAIL t5_epc_hold got=%h exp=%h", epc, 32'h3014); end
      fetch_exec(32'h0, 3'b111);
      checks++; if (imem_addr !== 32'h4188) begin errors++; $display("FAIL t5_other_code got=%h exp=%h", imem_addr, 32'h4188); end
      checks++; if (epc !== 32'h3014) begin errors++; $display("FAIL t5_epc_hold2 got=%h exp=%h", epc, 32'h3014); end
   endtask

   task automatic test_reset_mid_fetch();
      imem_ack = 1'b0;
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL t6_pre_req got=%b exp=1", imem_req); end
      rst = 1'b1;
      #1;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL t6_req_drop got=%b exp=0", imem_req); end
      checks++; if (pc !== 32'h3000) begin errors++; $display("FAIL t6_pc got=%h exp=%h", pc, 32'h3000); end
      checks++; if (nop !== 1'b1) begin errors++; $display("FAIL t6_nop got=%b exp=1", nop); end
      checks++; if (epc !== 32'h0) begin errors++; $display("FAIL t6_epc got=%h exp=%h", epc, 32'h0); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL t6_idle_req got=%b exp=0", imem_req); end
      checks++; if (nop !== 1'b1) begin errors++; $display("FAIL t6_idle_nop got=%b exp=1", nop); end
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      tick();
      imem_ack = 1'b0;
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL t6_fetch_req got=%b exp=1", imem_req); end
      checks++; if (imem_addr !== 32'h3000) begin errors++; $display("FAIL t6_fetch_addr got=%h exp=%h", imem_addr, 32'h3000); end
      checks++; if (instr !== 32'h0) begin errors++; $display("FAIL t6_late_ack got=%h exp=%h", instr, 32'h0); end
      checks++; if (nop !== 1'b1) begin errors++; $display("FAIL t6_fetch_nop got=%b exp=1", nop); end
      imem_ack   = 1'b1;
      imem_rdata = 32'h2408_0001;
      tick();
      imem_ack = 1'b0;
      checks++; if (nop !== 1'b0) begin errors++; $display("FAIL t6_exec_nop got=%b exp=0", nop); end
      checks++; if (instr !== 32'h2408_0001) begin errors++; $display("FAIL t6_exec_instr got=%h exp=%h", instr, 32'h2408_0001); end
      tick();
      checks++; if (imem_addr !== 32'h3004) begin errors++; $display("FAIL t6_next_addr got=%h exp=%h", imem_addr, 32'h3004); end
   endtask

   initial begin
      test_reset();
      test_fetch_basic();
      test_wrap();
      test_wait_states();
      test_branch();
      test_jump();
      test_except();
      test_reset_mid_fetch();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
